urv_dm_arbiter: RTL

URV_DM_ARBITER -- requirements
Module: urv_dm_arbiter

---
 rtl/urv_defs_pkg.sv | 22 ++
 rtl/urv_dm_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/urv_defs_pkg.sv
// -----------------------------------------------------------------------------
// urv_defs
// Shared definitions for the uRV memory arbiter.
//   arb_state_t : arbiter FSM state encoding
//   P_M0 / P_M1 : port-index constants (also the value of the load owner bit)
//   CNT_W       : width of the aux-starvation wait counter
// -----------------------------------------------------------------------------
package urv_defs;

  localparam int unsigned CNT_W = 4;

  localparam logic P_M0 = 1'b0;
  localparam logic P_M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_M0_WAIT = 2'd1,
    ST_M1_WAIT = 2'd2,
    ST_M1_LOCK = 2'd3
  } arb_state_t;

endpackage

// File: rtl/urv_dm_arbiter.sv
// -----------------------------------------------------------------------------
// urv_dm_arbiter
// Two-master arbiter in front of a single data-memory port. m0 is the core,
// m1 an aux (debug/DMA) master with starvation protection and a lock mode.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | arbitrate combinationally among current requests
// ST_M0_WAIT | m0 request presented, memory not ready yet; grant held on m0
// ST_M1_WAIT | m1 request presented, memory not ready yet; grant held on m1
// ST_M1_LOCK | m1 owns the memory exclusively while m1_lock_i stays high
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   m0_* / m1_*             master request (addr, store data, select,
//                           load, store), ready and load-done back
//   m1_lock_i               aux wants back-to-back ownership
//   m_data_l_o              load data, shared by both masters
//   mem_*                   forwarded request and memory handshake
// -----------------------------------------------------------------------------
module urv_dm_arbiter
  import urv_defs::*;
#(
  parameter int g_max_wait = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_s_i,
  input  logic [3:0]  m0_select_i,
  input  logic        m0_load_i,
  input  logic        m0_store_i,
  output logic        m0_ready_o,
  output logic        m0_load_done_o,

  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_s_i,
  input  logic [3:0]  m1_select_i,
  input  logic        m1_load_i,
  input  logic        m1_store_i,
  output logic        m1_ready_o,
  output logic        m1_load_done_o,
  input  logic        m1_lock_i,

  output logic [31:0] m_data_l_o,

  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_s_o,
  output logic [3:0]  mem_select_o,
  output logic        mem_load_o,
  output logic        mem_store_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_data_l_i
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(g_max_wait);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             done_q, done_d;

  logic m0_req, m1_req;
  logic gnt_vld, gnt_idx;
  logic sel_m1;
  logic sel_load, sel_store;
  logic accept;

  assign m0_req = m0_load_i | m0_store_i;
  assign m1_req = m1_load_i | m1_store_i;

  // Grant decode. In the wait/lock states the grant is pinned to the owning
  // master, but only while it still requests: a dropped request yields no
  // grant, so no strobe escapes. Reset masks every grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = P_M0;
    case (state_q)
      ST_IDLE: begin
        if (m1_req && (!m0_req || cnt_q == C_MAX)) begin
          gnt_vld = 1'b1;
          gnt_idx = P_M1;
        end else if (m0_req) begin
          gnt_vld = 1'b1;
        end
      end
      ST_M0_WAIT: gnt_vld = m0_req;
      ST_M1_WAIT, ST_M1_LOCK: begin
        gnt_vld = m1_req;
        gnt_idx = P_M1;
      end
      default: ;
    endcase
    if (rst_i) gnt_vld = 1'b0;
  end

  // With no grant the data path idles on m0; only the strobes are masked.
  assign sel_m1    = gnt_vld & (gnt_idx == P_M1);
  assign sel_load  = sel_m1 ? m1_load_i  : m0_load_i;
  assign sel_store = sel_m1 ? m1_store_i : m0_store_i;

  assign mem_addr_o   = sel_m1 ? m1_addr_i   : m0_addr_i;
  assign mem_data_s_o = sel_m1 ? m1_data_s_i : m0_data_s_i;
  assign mem_select_o = sel_m1 ? m1_select_i : m0_select_i;
  assign mem_store_o  = gnt_vld & sel_store;
  // load+store together is forwarded as a store only
  assign mem_load_o   = gnt_vld & sel_load & ~sel_store;

  assign accept     = gnt_vld & mem_ready_i;
  assign m0_ready_o = accept & (gnt_idx == P_M0);
  assign m1_ready_o = accept & (gnt_idx == P_M1);

  assign m_data_l_o = mem_data_l_i;

  assign m0_load_done_o = done_q & (owner_q == P_M0) & ~rst_i;
  assign m1_load_done_o = done_q & (owner_q == P_M1) & ~rst_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          if (!mem_ready_i)
            state_d = (gnt_idx == P_M1) ? ST_M1_WAIT : ST_M0_WAIT;
          else if (gnt_idx == P_M1 && m1_lock_i)
            state_d = ST_M1_LOCK;
        end
      end
      ST_M0_WAIT: begin
        if (!m0_req || mem_ready_i) state_d = ST_IDLE;
      end
      ST_M1_WAIT: begin
        if (!m1_req)          state_d = ST_IDLE;
        else if (mem_ready_i) state_d = m1_lock_i ? ST_M1_LOCK : ST_IDLE;
      end
      ST_M1_LOCK: begin
        // An m1 transfer still waiting on memory keeps the lock even if
        // m1_lock_i has already dropped.
        if (m1_req) begin
          if (mem_ready_i && !m1_lock_i) state_d = ST_IDLE;
        end else if (!m1_lock_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (m1_ready_o)
      cnt_d = '0;
    else if (m1_req && !sel_m1 && cnt_q < C_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    owner_d = owner_q;
    done_d  = accept & mem_load_o;
    if (accept && mem_load_o) owner_d = gnt_idx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      owner_q <= P_M0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      done_q  <= done_d;
    end
  end

endmodule
